// File: rtl/line_burst_memory.sv
// -----------------------------------------------------------------------------
// line_burst_memory
//
// Behavioural dual-port main memory for the cached pipelined CPU.
//   * Instruction port: read-only, returns a whole cache line as a burst.
//   * Data port: line-read bursts or single-word write-through writes.
// Each port has its own latency model and its own line buffer, so the two
// ports never interact except through the shared storage array.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   i_req, i_addr                instruction line-read request / word address
//   i_busy, i_valid, i_beat,     instruction port status and burst beat
//   i_rdata
//   d_req, d_we, d_addr, d_wdata data request (d_we=1 write, 0 line read)
//   d_busy, d_valid, d_beat,     data port status and burst beat
//   d_rdata, d_ack               (d_ack: one-cycle write-complete pulse)
//
// Optional build macro
//   MEM_ACCESS_STATS_EN  adds saturating 16-bit counters stat_i_lines,
//                        stat_d_lines and stat_d_writes (cleared by reset).
//
// Only the low ADDR_W address bits select a word; upper bits are ignored.
// Storage contents are never touched by reset.
// -----------------------------------------------------------------------------
module line_burst_memory #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int I_LATENCY  = 2,
  parameter int D_LATENCY  = 3,
  parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(16'hF000),
  localparam int BEAT_W    = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_busy,
  output logic              i_valid,
  output logic [BEAT_W-1:0] i_beat,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_busy,
  output logic              d_valid,
  output logic [BEAT_W-1:0] d_beat,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ack
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]       stat_i_lines,
  output logic [15:0]       stat_d_lines,
  output logic [15:0]       stat_d_writes
`endif
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LINE_W  = ADDR_W - BEAT_W;
  localparam int MAX_LAT = (I_LATENCY > D_LATENCY) ? I_LATENCY : D_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST,
    ST_WWAIT
  } state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  // Per-port line snapshots taken at acceptance.
  logic [WORD_W-1:0] i_line_p0 [LINE_WORDS];
  logic [WORD_W-1:0] d_line_p0 [LINE_WORDS];

  state_t            i_state;
  state_t            d_state;
  logic [CNT_W-1:0]  i_cnt;
  logic [CNT_W-1:0]  d_cnt;

  logic [LINE_W-1:0] i_base;
  logic [LINE_W-1:0] d_base;
  logic [BEAT_W-1:0] i_beat_nxt;
  logic [BEAT_W-1:0] d_beat_nxt;
  logic              i_accept;
  logic              d_accept;

  assign i_base     = i_addr[ADDR_W-1:BEAT_W];
  assign d_base     = d_addr[ADDR_W-1:BEAT_W];
  assign i_beat_nxt = i_beat + 1'b1;
  assign d_beat_nxt = d_beat + 1'b1;
  assign i_accept   = reset_n && (i_state == ST_IDLE) && i_req;
  assign d_accept   = reset_n && (d_state == ST_IDLE) && d_req;

  // Address bits that never select storage: upper bits on both ports and the
  // word-in-line bits of the read-only instruction port.
  logic unused_addr;
  assign unused_addr = ^{i_addr[WORD_W-1:ADDR_W], i_addr[BEAT_W-1:0],
                         d_addr[WORD_W-1:ADDR_W]};

  // ---------------------------------------------------------------------------
  // Stage p0: storage write and line snapshots at the acceptance edge.
  // The snapshot reads the pre-edge array, so a read accepted together with a
  // write to the same line sees the old data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (d_accept && d_we) begin
      mem[d_addr[ADDR_W-1:0]] <= d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_accept) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        i_line_p0[k] <= mem[{i_base, BEAT_W'(k)}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (d_accept && !d_we) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        d_line_p0[k] <= mem[{d_base, BEAT_W'(k)}];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: instruction port sequencer, IDLE -> WAIT -> BURST -> IDLE.
  // WAIT holds for I_LATENCY-1 cycles; with I_LATENCY=1 beat 0 is launched
  // straight from the array at acceptance.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_state <= ST_IDLE;
      i_cnt   <= '0;
      i_busy  <= 1'b0;
      i_valid <= 1'b0;
      i_beat  <= '0;
      i_rdata <= IDLE_WORD;
    end else begin
      case (i_state)
        ST_IDLE: begin
          if (i_req) begin
            i_busy <= 1'b1;
            if (I_LATENCY == 1) begin
              i_state <= ST_BURST;
              i_valid <= 1'b1;
              i_beat  <= '0;
              i_rdata <= mem[{i_base, BEAT_W'(0)}];
            end else begin
              i_state <= ST_WAIT;
              i_cnt   <= CNT_W'((I_LATENCY > 1) ? I_LATENCY - 2 : 0);
            end
          end
        end
        ST_WAIT: begin
          if (i_cnt == '0) begin
            i_state <= ST_BURST;
            i_valid <= 1'b1;
            i_beat  <= '0;
            i_rdata <= i_line_p0[0];
          end else begin
            i_cnt <= i_cnt - 1'b1;
          end
        end
        ST_BURST: begin
          if (i_beat == BEAT_W'(LINE_WORDS - 1)) begin
            i_state <= ST_IDLE;
            i_busy  <= 1'b0;
            i_valid <= 1'b0;
            i_beat  <= '0;
            i_rdata <= IDLE_WORD;
          end else begin
            i_beat  <= i_beat_nxt;
            i_rdata <= i_line_p0[i_beat_nxt];
          end
        end
        default: begin
          i_state <= ST_IDLE;
          i_busy  <= 1'b0;
          i_valid <= 1'b0;
          i_beat  <= '0;
          i_rdata <= IDLE_WORD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: data port sequencer. Reads follow the same path as the
  // instruction port; writes go IDLE -> WWAIT -> IDLE, with d_cnt counting
  // down to the cycle where d_ack is raised, then one ack cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_state <= ST_IDLE;
      d_cnt   <= '0;
      d_busy  <= 1'b0;
      d_valid <= 1'b0;
      d_beat  <= '0;
      d_rdata <= IDLE_WORD;
      d_ack   <= 1'b0;
    end else begin
      case (d_state)
        ST_IDLE: begin
          if (d_req) begin
            d_busy <= 1'b1;
            if (d_we) begin
              d_state <= ST_WWAIT;
              d_cnt   <= CNT_W'(D_LATENCY - 1);
              d_ack   <= (D_LATENCY == 1);
            end else if (D_LATENCY == 1) begin
              d_state <= ST_BURST;
              d_valid <= 1'b1;
              d_beat  <= '0;
              d_rdata <= mem[{d_base, BEAT_W'(0)}];
            end else begin
              d_state <= ST_WAIT;
              d_cnt   <= CNT_W'((D_LATENCY > 1) ? D_LATENCY - 2 : 0);
            end
          end
        end
        ST_WAIT: begin
          if (d_cnt == '0) begin
            d_state <= ST_BURST;
            d_valid <= 1'b1;
            d_beat  <= '0;
            d_rdata <= d_line_p0[0];
          end else begin
            d_cnt <= d_cnt - 1'b1;
          end
        end
        ST_BURST: begin
          if (d_beat == BEAT_W'(LINE_WORDS - 1)) begin
            d_state <= ST_IDLE;
            d_busy  <= 1'b0;
            d_valid <= 1'b0;
            d_beat  <= '0;
            d_rdata <= IDLE_WORD;
          end else begin
            d_beat  <= d_beat_nxt;
            d_rdata <= d_line_p0[d_beat_nxt];
          end
        end
        ST_WWAIT: begin
          if (d_ack) begin
            d_state <= ST_IDLE;
            d_busy  <= 1'b0;
            d_ack   <= 1'b0;
          end else begin
            if (d_cnt == CNT_W'(1)) begin
              d_ack <= 1'b1;
            end
            d_cnt <= d_cnt - 1'b1;
          end
        end
        default: begin
          d_state <= ST_IDLE;
          d_busy  <= 1'b0;
          d_valid <= 1'b0;
          d_beat  <= '0;
          d_rdata <= IDLE_WORD;
          d_ack   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  // ---------------------------------------------------------------------------
  // Stage p1: saturating access counters, one per accepted request type.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_i_lines  <= '0;
      stat_d_lines  <= '0;
      stat_d_writes <= '0;
    end else begin
      if (i_accept && (stat_i_lines != 16'hFFFF)) begin
        stat_i_lines <= stat_i_lines + 16'd1;
      end
      if (d_accept && !d_we && (stat_d_lines != 16'hFFFF)) begin
        stat_d_lines <= stat_d_lines + 16'd1;
      end
      if (d_accept && d_we && (stat_d_writes != 16'hFFFF)) begin
        stat_d_writes <= stat_d_writes + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_burst_memory.sv
// -----------------------------------------------------------------------------
// tb_line_burst_memory
//
// Self-checking bench for line_burst_memory. The reference model tracks the
// storage contents and, per port, the number of cycles since the last accepted
// request; expected outputs follow directly from that age and the latency
// rules. Inputs change on the falling edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_line_burst_memory;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 8;
  localparam int LW     = 4;
  localparam int BW     = 2;
  localparam int I_LAT  = 2;
  localparam int D_LAT  = 3;
  localparam logic [15:0] IDLE = 16'hF000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;

  logic          i_busy, i_valid, d_busy, d_valid, d_ack;
  logic [BW-1:0] i_beat, d_beat;
  logic [15:0]   i_rdata, d_rdata;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0]   stat_i_lines, stat_d_lines, stat_d_writes;
`endif

  line_burst_memory #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_WORDS(LW),
    .I_LATENCY(I_LAT), .D_LATENCY(D_LAT), .IDLE_WORD(IDLE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_valid(i_valid),
    .i_beat(i_beat), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_busy(d_busy), .d_valid(d_valid), .d_beat(d_beat), .d_rdata(d_rdata),
    .d_ack(d_ack)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_i_lines(stat_i_lines), .stat_d_lines(stat_d_lines),
    .stat_d_writes(stat_d_writes)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  logic [15:0] ref_mem [256];
  logic [15:0] i_line [LW];
  logic [15:0] d_line [LW];
  int          i_age = -1;
  int          d_age = -1;
  bit          d_is_wr = 1'b0;
  logic [19:0] exp_i;
  logic [20:0] exp_d;

  wire [19:0] i_obs = {i_busy, i_valid, i_beat, i_rdata};
  wire [20:0] d_obs = {d_busy, d_valid, d_beat, d_rdata, d_ack};

  // Commit the current inputs to the model, cross one rising edge, and derive
  // the expected outputs for the new cycle from each port's age.
  task automatic tick();
    if (!reset_n) begin
      i_age = -1;
      d_age = -1;
    end else begin
      if (i_age < 0 && i_req) begin
        for (int k = 0; k < LW; k++) i_line[k] = ref_mem[{i_addr[7:2], 2'(k)}];
        i_age = 0;
      end
      if (d_age < 0 && d_req) begin
        d_is_wr = d_we;
        if (d_we) ref_mem[d_addr[7:0]] = d_wdata;
        else for (int k = 0; k < LW; k++) d_line[k] = ref_mem[{d_addr[7:2], 2'(k)}];
        d_age = 0;
      end
    end
    @(negedge clk);
    cyc++;
    if (i_age >= 0) i_age++;
    if (i_age >= I_LAT + LW) i_age = -1;
    if (d_age >= 0) d_age++;
    if (d_age >= (d_is_wr ? D_LAT + 1 : D_LAT + LW)) d_age = -1;

    if (i_age >= I_LAT) exp_i = {2'b11, 2'(i_age - I_LAT), i_line[i_age - I_LAT]};
    else if (i_age >= 1) exp_i = {2'b10, 2'b00, IDLE};
    else exp_i = {2'b00, 2'b00, IDLE};

    if (d_age >= 1 && d_is_wr) exp_d = {2'b10, 2'b00, IDLE, (d_age == D_LAT)};
    else if (d_age >= D_LAT) exp_d = {2'b11, 2'(d_age - D_LAT), d_line[d_age - D_LAT], 1'b0};
    else if (d_age >= 1) exp_d = {2'b10, 2'b00, IDLE, 1'b0};
    else exp_d = {2'b00, 2'b00, IDLE, 1'b0};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0055; d_wdata = 16'hDEAD;
    repeat (3) tick();
    checks += 2;
    if (i_obs !== {2'b00, 2'b00, 16'hF000}) begin
      failures++; $display("FAIL reset_i got=%h want=%h", i_obs, {2'b00, 2'b00, 16'hF000});
    end
    if (d_obs !== {2'b00, 2'b00, 16'hF000, 1'b0}) begin
      failures++; $display("FAIL reset_d got=%h want=%h", d_obs, {2'b00, 2'b00, 16'hF000, 1'b0});
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_preload();
    for (int a = 0; a < 256; a++) begin
      for (int c = 0; c <= D_LAT; c++) begin
        if (c == 0) begin
          d_req = 1'b1; d_we = 1'b1;
          d_addr = {8'($urandom), 8'(a)}; d_wdata = 16'($urandom);
        end else begin
          d_req = 1'b0; d_we = 1'b0;
        end
        tick();
        checks++;
        if (d_obs !== exp_d) begin
          failures++; $display("FAIL preload_d cyc=%0d got=%h want=%h", cyc, d_obs, exp_d);
        end
      end
    end
  endtask

  task automatic test_i_burst();
    int first_valid;
    int nbeats;
    for (int k = 0; k < LW; k++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020 + 16'(k); d_wdata = 16'h00A0 + 16'(k);
      tick();
      d_req = 1'b0; d_we = 1'b0;
      repeat (D_LAT) tick();
    end
    first_valid = -1;
    nbeats = 0;
    i_req = 1'b1; i_addr = 16'h0022;
    for (int c = 1; c <= I_LAT + LW; c++) begin
      tick();
      i_req = 1'b0;
      checks++;
      if (i_obs !== exp_i) begin
        failures++; $display("FAIL i_burst cyc=%0d got=%h want=%h", c, i_obs, exp_i);
      end
      if (i_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        checks++;
        if ({i_beat, i_rdata} !== {2'(nbeats), 16'h00A0 + 16'(nbeats)}) begin
          failures++; $display("FAIL i_burst_data cyc=%0d got=%h want=%h", c, {i_beat, i_rdata},
                               {2'(nbeats), 16'h00A0 + 16'(nbeats)});
        end
        nbeats++;
      end
    end
    checks += 3;
    if (first_valid != 2) begin
      failures++; $display("FAIL i_first_beat_cycle got=%0d want=2", first_valid);
    end
    if (nbeats != 4) begin
      failures++; $display("FAIL i_beat_count got=%0d want=4", nbeats);
    end
    if (i_busy !== 1'b0) begin
      failures++; $display("FAIL i_busy_cycle6 got=%b want=0", i_busy);
    end
  endtask

  task automatic test_write_ack();
    int ack_cnt;
    int ack_cyc;
    logic [15:0] beat1;
    ack_cnt = 0; ack_cyc = -1; beat1 = 'x;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0041; d_wdata = 16'h1234;
    for (int c = 1; c <= D_LAT + 1; c++) begin
      tick();
      d_req = 1'b0; d_we = 1'b0;
      checks++;
      if (d_obs !== exp_d) begin
        failures++; $display("FAIL write_ack_d cyc=%0d got=%h want=%h", c, d_obs, exp_d);
      end
      if (d_ack === 1'b1) begin ack_cnt++; ack_cyc = c; end
    end
    checks++;
    if (ack_cnt != 1 || ack_cyc != 3) begin
      failures++; $display("FAIL write_ack_timing got=%0d@%0d want=1@3", ack_cnt, ack_cyc);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    for (int c = 1; c <= D_LAT + LW; c++) begin
      tick();
      d_req = 1'b0;
      checks++;
      if (d_obs !== exp_d) begin
        failures++; $display("FAIL write_readback_d cyc=%0d got=%h want=%h", c, d_obs, exp_d);
      end
      if (d_valid === 1'b1 && d_beat == 2'd1) beat1 = d_rdata;
    end
    checks++;
    if (beat1 !== 16'h1234) begin
      failures++; $display("FAIL write_visible got=%h want=1234", beat1);
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] got0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5A5A;
    tick();
    d_req = 1'b0; d_we = 1'b0;
    repeat (D_LAT) tick();
    got0 = 'x;
    i_req = 1'b1; i_addr = 16'h0030;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
    for (int c = 1; c <= I_LAT + LW; c++) begin
      tick();
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      checks += 2;
      if (i_obs !== exp_i) begin
        failures++; $display("FAIL same_cycle_i cyc=%0d got=%h want=%h", c, i_obs, exp_i);
      end
      if (d_obs !== exp_d) begin
        failures++; $display("FAIL same_cycle_d cyc=%0d got=%h want=%h", c, d_obs, exp_d);
      end
      if (i_valid === 1'b1 && i_beat == 2'd0) got0 = i_rdata;
    end
    checks++;
    if (got0 !== 16'h5A5A) begin
      failures++; $display("FAIL same_cycle_old got=%h want=5a5a", got0);
    end
    got0 = 'x;
    i_req = 1'b1; i_addr = 16'h0030;
    for (int c = 1; c <= I_LAT + LW; c++) begin
      tick();
      i_req = 1'b0;
      checks++;
      if (i_obs !== exp_i) begin
        failures++; $display("FAIL same_cycle_next_i cyc=%0d got=%h want=%h", c, i_obs, exp_i);
      end
      if (i_valid === 1'b1 && i_beat == 2'd0) got0 = i_rdata;
    end
    checks++;
    if (got0 !== 16'hBEEF) begin
      failures++; $display("FAIL same_cycle_new got=%h want=beef", got0);
    end
  endtask

  task automatic test_back_to_back();
    int nbeats;
    nbeats = 0;
    i_req = 1'b1; i_addr = 16'h0021;
    for (int c = 1; c <= 3 * (I_LAT + LW); c++) begin
      tick();
      checks++;
      if (i_obs !== exp_i) begin
        failures++; $display("FAIL b2b_i cyc=%0d got=%h want=%h", c, i_obs, exp_i);
      end
      if (i_valid === 1'b1) begin
        checks++;
        if ({i_beat, i_rdata} !== {2'(nbeats % LW), 16'h00A0 + 16'(nbeats % LW)}) begin
          failures++; $display("FAIL b2b_beat cyc=%0d got=%h want=%h", c, {i_beat, i_rdata},
                               {2'(nbeats % LW), 16'h00A0 + 16'(nbeats % LW)});
        end
        nbeats++;
      end
    end
    i_req = 1'b0;
    checks++;
    if (nbeats != 3 * LW) begin
      failures++; $display("FAIL b2b_beat_total got=%0d want=%0d", nbeats, 3 * LW);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    i_req = 1'b1; i_addr = 16'h0020;
    for (int c = 1; c <= D_LAT + 1; c++) begin
      tick();
      d_req = 1'b0; i_req = 1'b0;
      checks += 2;
      if (d_obs !== exp_d) begin
        failures++; $display("FAIL mid_pre_d cyc=%0d got=%h want=%h", c, d_obs, exp_d);
      end
      if (i_obs !== exp_i) begin
        failures++; $display("FAIL mid_pre_i cyc=%0d got=%h want=%h", c, i_obs, exp_i);
      end
    end
    checks++;
    if ({d_valid, d_beat} !== 3'b101) begin
      failures++; $display("FAIL mid_at_beat1 got=%b want=101", {d_valid, d_beat});
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks += 2;
    if (d_obs !== {2'b00, 2'b00, 16'hF000, 1'b0}) begin
      failures++; $display("FAIL mid_reset_d got=%h want=%h", d_obs, {2'b00, 2'b00, 16'hF000, 1'b0});
    end
    if (i_obs !== {2'b00, 2'b00, 16'hF000}) begin
      failures++; $display("FAIL mid_reset_i got=%h want=%h", i_obs, {2'b00, 2'b00, 16'hF000});
    end
    repeat (2) begin
      tick();
      checks++;
      if ({i_obs, d_obs} !== {exp_i, exp_d}) begin
        failures++; $display("FAIL mid_quiet got=%h want=%h", {i_obs, d_obs}, {exp_i, exp_d});
      end
    end
    // Reset during a write: the write was committed at acceptance.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0077; d_wdata = 16'hC0DE;
    tick();
    d_req = 1'b0; d_we = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (d_obs !== {2'b00, 2'b00, 16'hF000, 1'b0}) begin
      failures++; $display("FAIL mid_write_reset got=%h want=%h", d_obs, {2'b00, 2'b00, 16'hF000, 1'b0});
    end
    got = 'x;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0074;
    for (int c = 1; c <= D_LAT + LW; c++) begin
      tick();
      d_req = 1'b0;
      checks++;
      if (d_obs !== exp_d) begin
        failures++; $display("FAIL mid_after_d cyc=%0d got=%h want=%h", c, d_obs, exp_d);
      end
      if (d_valid === 1'b1 && d_beat == 2'd3) got = d_rdata;
    end
    checks++;
    if (got !== 16'hC0DE) begin
      failures++; $display("FAIL mid_write_kept got=%h want=c0de", got);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      i_req = ($urandom_range(0, 2) == 0);
      i_addr = 16'($urandom);
      d_req = ($urandom_range(0, 2) == 0);
      d_we = $urandom_range(0, 1) == 1;
      d_addr = 16'($urandom);
      d_wdata = 16'($urandom);
      tick();
      checks += 2;
      if (i_obs !== exp_i) begin
        failures++; $display("FAIL random_i cyc=%0d got=%h want=%h", cyc, i_obs, exp_i);
      end
      if (d_obs !== exp_d) begin
        failures++; $display("FAIL random_d cyc=%0d got=%h want=%h", cyc, d_obs, exp_d);
      end
    end
    reset_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (I_LAT + LW + 1) tick();
  endtask

`ifdef MEM_ACCESS_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({stat_i_lines, stat_d_lines, stat_d_writes} !== 48'h0) begin
      failures++; $display("FAIL stats_cleared got=%h want=0", {stat_i_lines, stat_d_lines, stat_d_writes});
    end
    for (int r = 0; r < 3; r++) begin
      i_req = 1'b1; i_addr = 16'(r * 4);
      if (r < 2) begin d_req = 1'b1; d_we = 1'b0; d_addr = 16'(r * 8); end
      tick();
      i_req = 1'b0; d_req = 1'b0;
      repeat (D_LAT + LW) tick();
    end
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0090; d_wdata = 16'h0F0F;
    tick();
    d_req = 1'b0; d_we = 1'b0;
    repeat (D_LAT + 1) tick();
    checks++;
    if ({stat_i_lines, stat_d_lines, stat_d_writes} !== {16'd3, 16'd2, 16'd1}) begin
      failures++; $display("FAIL stats_count got=%h want=%h", {stat_i_lines, stat_d_lines, stat_d_writes},
                           {16'd3, 16'd2, 16'd1});
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({stat_i_lines, stat_d_lines, stat_d_writes} !== 48'h0) begin
      failures++; $display("FAIL stats_reset got=%h want=0", {stat_i_lines, stat_d_lines, stat_d_writes});
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_preload();
    test_i_burst();
    test_write_ack();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEM_ACCESS_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
